// File: rtl/alu_exec_unit_if.sv
// Valid/ready request and response bundle between the execute-stage issuer
// and alu_exec_unit.
interface alu_exec_unit_if #(parameter int WIDTH = 32);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       alu_control;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;

    modport master (
        output in_valid, alu_control, op_a, op_b, out_ready,
        input  in_ready, out_valid, result, zero
    );

    modport slave (
        input  in_valid, alu_control, op_a, op_b, out_ready,
        output in_ready, out_valid, result, zero
    );
endinterface

// File: rtl/alu_exec_unit.sv
// Multi-cycle ALU: logic/arith/compare finish in one cycle, shifts iterate one
// bit per cycle. Result and zero are registered and held until handshake.
module alu_exec_unit #(
    parameter int WIDTH = 32
) (
    input logic            clk,
    input logic            rst_n,
    alu_exec_unit_if.slave bus
);
    localparam int SW = $clog2(WIDTH);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_XOR  = 4'b0011;
    localparam logic [3:0] OP_SLL  = 4'b0100;
    localparam logic [3:0] OP_SRL  = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SRA  = 4'b0111;
    localparam logic [3:0] OP_SLT  = 4'b1000;
    localparam logic [3:0] OP_SLTU = 4'b1001;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state_q, state_d;
    logic [3:0]       ctrl_q, ctrl_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [SW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;

    logic             accept;
    logic             is_shift;
    logic             start_shift;
    logic [SW-1:0]    amount;
    logic [WIDTH-1:0] quick_res;
    logic [WIDTH-1:0] acc_shifted;

    assign accept      = bus.in_valid && (state_q == IDLE);
    assign amount      = bus.op_b[SW-1:0];
    assign is_shift    = (bus.alu_control == OP_SLL) || (bus.alu_control == OP_SRL) ||
                         (bus.alu_control == OP_SRA);
    assign start_shift = is_shift && (amount != '0);

    // Shift codes fall through to op_a so a zero-amount shift completes here.
    always_comb begin
        quick_res = '0;
        case (bus.alu_control)
            OP_AND:  quick_res = bus.op_a & bus.op_b;
            OP_OR:   quick_res = bus.op_a | bus.op_b;
            OP_ADD:  quick_res = bus.op_a + bus.op_b;
            OP_XOR:  quick_res = bus.op_a ^ bus.op_b;
            OP_SUB:  quick_res = bus.op_a - bus.op_b;
            OP_SLT:  quick_res = {{(WIDTH-1){1'b0}}, $signed(bus.op_a) < $signed(bus.op_b)};
            OP_SLTU: quick_res = {{(WIDTH-1){1'b0}}, bus.op_a < bus.op_b};
            OP_SLL, OP_SRL, OP_SRA: quick_res = bus.op_a;
            default: quick_res = '0;
        endcase
    end

    always_comb begin
        acc_shifted = acc_q;
        case (ctrl_q)
            OP_SLL:  acc_shifted = {acc_q[WIDTH-2:0], 1'b0};
            OP_SRL:  acc_shifted = {1'b0, acc_q[WIDTH-1:1]};
            default: acc_shifted = {acc_q[WIDTH-1], acc_q[WIDTH-1:1]};
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = start_shift ? SHIFT : DONE;
            SHIFT:   if (cnt_q == SW'(1)) state_d = DONE;
            DONE:    if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = (state_q == IDLE);
        bus.out_valid = (state_q == DONE);
    end

    assign bus.result = result_q;
    assign bus.zero   = zero_q;

    // The counter is checked before decrement, so the last shift and the
    // result write land on the same edge as the move to DONE.
    always_comb begin
        ctrl_d   = ctrl_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        zero_d   = zero_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    ctrl_d = bus.alu_control;
                    if (start_shift) begin
                        acc_d = bus.op_a;
                        cnt_d = amount;
                    end else begin
                        result_d = quick_res;
                        zero_d   = (quick_res == '0);
                    end
                end
            end
            SHIFT: begin
                acc_d = acc_shifted;
                cnt_d = cnt_q - SW'(1);
                if (cnt_q == SW'(1)) begin
                    result_d = acc_shifted;
                    zero_d   = (acc_shifted == '0);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q   <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            zero_q   <= 1'b1;
        end else begin
            ctrl_q   <= ctrl_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            zero_q   <= zero_d;
        end
    end
endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit: reset, single-cycle ops, shifts,
// backpressure, reset abort and a short reference-model stream.
module tb_alu_exec_unit;
    logic clk;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;
    int   lat;
    int   gap;
    int   hold;
    logic seen_valid;
    logic [3:0]  s_ctrl;
    logic [31:0] s_a, s_b, s_exp;

    alu_exec_unit_if #(.WIDTH(32)) bus ();

    alu_exec_unit #(.WIDTH(32)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // Inputs are scrambled right after the accepting edge so any late
    // sampling of op_a/op_b/alu_control shows up as a wrong result.
    task automatic applyStimulus(input logic [3:0] ctrl, input logic [31:0] a,
                                 input logic [31:0] b);
        int n = 0;
        while (bus.in_ready !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        if (bus.in_ready !== 1'b1) checkOutput("in_ready_timeout", {31'b0, bus.in_ready}, 32'd1);
        bus.in_valid    = 1'b1;
        bus.alu_control = ctrl;
        bus.op_a        = a;
        bus.op_b        = b;
        tick();
        bus.in_valid    = 1'b0;
        bus.alu_control = ~ctrl;
        bus.op_a        = ~a;
        bus.op_b        = ~b;
    endtask

    task automatic waitValid(output int cycles);
        cycles = 1;
        while (bus.out_valid !== 1'b1 && cycles <= 64) begin
            tick();
            cycles++;
        end
        if (bus.out_valid !== 1'b1) checkOutput("out_valid_timeout", {31'b0, bus.out_valid}, 32'd1);
    endtask

    task automatic runOp(input string tag, input logic [3:0] ctrl, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
        int l;
        applyStimulus(ctrl, a, b);
        waitValid(l);
        checkOutput({tag, ".result"}, bus.result, exp);
        checkOutput({tag, ".zero"}, {31'b0, bus.zero}, {31'b0, exp == 32'd0});
        checkOutput({tag, ".latency"}, 32'(l), 32'(exp_lat));
        tick();
        checkOutput({tag, ".valid_one_cycle"}, {31'b0, bus.out_valid}, 32'd0);
    endtask

    function automatic logic [31:0] refAlu(input logic [3:0] c, input logic [31:0] a,
                                           input logic [31:0] b);
        case (c)
            4'd0:    return a & b;
            4'd1:    return a | b;
            4'd2:    return a + b;
            4'd3:    return a ^ b;
            4'd4:    return a << b[4:0];
            4'd5:    return a >> b[4:0];
            4'd6:    return a - b;
            4'd7:    return 32'($signed(a) >>> b[4:0]);
            4'd8:    return {31'b0, $signed(a) < $signed(b)};
            4'd9:    return {31'b0, a < b};
            default: return 32'd0;
        endcase
    endfunction

    initial begin
        rst_n           = 1'b0;
        bus.in_valid    = 1'b0;
        bus.alu_control = 4'd0;
        bus.op_a        = 32'd0;
        bus.op_b        = 32'd0;
        bus.out_ready   = 1'b1;
        tick();
        tick();
        checkOutput("reset.in_ready", {31'b0, bus.in_ready}, 32'd1);
        checkOutput("reset.out_valid", {31'b0, bus.out_valid}, 32'd0);
        checkOutput("reset.result", bus.result, 32'd0);
        checkOutput("reset.zero", {31'b0, bus.zero}, 32'd1);
        rst_n = 1'b1;
        tick();

        // Single-cycle operations
        runOp("and",  4'b0000, 32'hFFFF_FFF0, 32'h0000_0010, 32'h0000_0010, 1);
        runOp("or",   4'b0001, 32'hFFFF_FFF0, 32'h0000_0010, 32'hFFFF_FFF0, 1);
        runOp("add",  4'b0010, 32'hFFFF_FFF0, 32'h0000_0010, 32'h0000_0000, 1);
        runOp("xor",  4'b0011, 32'hFFFF_FFF0, 32'h0000_0010, 32'hFFFF_FFE0, 1);
        runOp("sub",  4'b0110, 32'hFFFF_FFF0, 32'h0000_0010, 32'hFFFF_FFE0, 1);
        runOp("slt",  4'b1000, 32'hFFFF_FFF0, 32'h0000_0010, 32'h0000_0001, 1);
        runOp("sltu", 4'b1001, 32'hFFFF_FFF0, 32'h0000_0010, 32'h0000_0000, 1);
        runOp("undef", 4'b1111, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1);

        // Iterative shifts
        runOp("sll4",   4'b0100, 32'h8000_0001, 32'h0000_0004, 32'h0000_0010, 5);
        runOp("srl31",  4'b0101, 32'h8000_0001, 32'h0000_001F, 32'h0000_0001, 32);
        runOp("sra4",   4'b0111, 32'h8000_0001, 32'h0000_0004, 32'hF800_0000, 5);
        runOp("sll_hi", 4'b0100, 32'h8000_0001, 32'h0000_0024, 32'h0000_0010, 5);
        runOp("sra0",   4'b0111, 32'h8000_0001, 32'h0000_0000, 32'h8000_0001, 1);

        // Backpressure: result held, requests ignored while in DONE
        bus.out_ready = 1'b0;
        applyStimulus(4'b0000, 32'hFFFF_FFF0, 32'h0000_0010);
        waitValid(lat);
        checkOutput("bp.result_first", bus.result, 32'h0000_0010);
        for (int i = 0; i < 10; i++) begin
            bus.in_valid    = i[0];
            bus.alu_control = 4'b0001;
            bus.op_a        = 32'h0000_0005;
            bus.op_b        = 32'h0000_0006;
            tick();
            checkOutput("bp.out_valid", {31'b0, bus.out_valid}, 32'd1);
            checkOutput("bp.in_ready", {31'b0, bus.in_ready}, 32'd0);
            checkOutput("bp.result", bus.result, 32'h0000_0010);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        checkOutput("bp.release_valid", {31'b0, bus.out_valid}, 32'd0);
        checkOutput("bp.release_ready", {31'b0, bus.in_ready}, 32'd1);
        seen_valid = 1'b0;
        repeat (3) begin
            tick();
            if (bus.out_valid === 1'b1) seen_valid = 1'b1;
        end
        checkOutput("bp.no_ghost_op", {31'b0, seen_valid}, 32'd0);

        // Reset in the middle of a shift abandons it
        applyStimulus(4'b0100, 32'hFFFF_FFFF, 32'h0000_0014);
        repeat (5) tick();
        rst_n = 1'b0;
        #1;
        checkOutput("rst_mid.in_ready", {31'b0, bus.in_ready}, 32'd1);
        checkOutput("rst_mid.out_valid", {31'b0, bus.out_valid}, 32'd0);
        checkOutput("rst_mid.result", bus.result, 32'd0);
        checkOutput("rst_mid.zero", {31'b0, bus.zero}, 32'd1);
        tick();
        rst_n = 1'b1;
        seen_valid = 1'b0;
        repeat (30) begin
            tick();
            if (bus.out_valid === 1'b1) seen_valid = 1'b1;
        end
        checkOutput("rst_mid.no_stale", {31'b0, seen_valid}, 32'd0);

        // Random stream with idle gaps and consumer stalls
        for (int k = 0; k < 100; k++) begin
            s_ctrl = 4'($urandom_range(0, 15));
            s_a    = $urandom;
            s_b    = $urandom;
            s_exp  = refAlu(s_ctrl, s_a, s_b);
            gap    = $urandom_range(0, 2);
            repeat (gap) tick();
            bus.out_ready = 1'b0;
            applyStimulus(s_ctrl, s_a, s_b);
            waitValid(lat);
            hold = $urandom_range(0, 3);
            repeat (hold) tick();
            checkOutput("stream.result", bus.result, s_exp);
            bus.out_ready = 1'b1;
            tick();
            checkOutput("stream.single_valid", {31'b0, bus.out_valid}, 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
